// File: rtl/delay_mon_pkg.sv
// Shared types and constants for the delay pulse monitor.
// Used by delay_pulse_monitor and delay_interval_ctr.
package delay_mon_pkg;

   // Lock state of the monitor.
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } mon_state_t;

   // Width of the saturating early+late error counter.
   localparam int ERR_CNT_W = 8;

   // Saturating increment for the error counter.
   function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
      logic [ERR_CNT_W-1:0] r;
      r = v;
      if (v != {ERR_CNT_W{1'b1}}) begin
         r = v + 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/delay_interval_ctr.sv
// Interval counter for the delay pulse monitor.
// cnt_o counts cycles since the last reference pulse; it reads 0 on the cycle
// after the pulse. The compare outputs classify the interval that a pulse on
// the current cycle would close (I = cnt_o + 1):
//   early_o   : I <  N+1-TOL
//   good_o    : N+1-TOL <= I <= N+1+TOL
//   timeout_o : cnt_o == N+TOL, the last cycle a pulse can still be good
// The counter never runs past N+TOL, so it cannot wrap.
module delay_interval_ctr
   import delay_mon_pkg::*;
#(
   parameter int N     = 10000,
   parameter int CBITS = 14,
   parameter int TOL   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             hold_i,
   output logic [CBITS-1:0] cnt_o,
   output logic             early_o,
   output logic             good_o,
   output logic             timeout_o
);

   localparam logic [CBITS-1:0] GOOD_MIN_CNT = CBITS'(N - TOL);
   localparam logic [CBITS-1:0] TMO_CNT      = CBITS'(N + TOL);

   logic [CBITS-1:0] cnt_q;
   logic [CBITS-1:0] cnt_d;

   // Next count: hold/clear force zero, otherwise count up and park at the timeout value.
   always_comb begin
      cnt_d = cnt_q;
      if (hold_i || clear_i) begin
         cnt_d = '0;
      end else if (cnt_q != TMO_CNT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign early_o   = (cnt_q < GOOD_MIN_CNT);
   assign good_o    = (cnt_q >= GOOD_MIN_CNT) && (cnt_q <= TMO_CNT);
   assign timeout_o = (cnt_q == TMO_CNT);

endmodule

// File: rtl/delay_pulse_monitor.sv
// Receive-side checker for the periodic delay pulse. Measures the interval
// between pulses, locks after GOOD_REQ consecutive good intervals and flags
// early and missing (late) pulses. All outputs are registered.
//
// Build option: define DELAY_MON_STICKY_EN to make early_err/late_err sticky
// until reset; otherwise each flag is a one-cycle pulse per event.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   HUNT   | no reference pulse yet; counter held at 0
//   TRACK  | reference seen, counting good intervals towards lock
//   LOCKED | GOOD_REQ consecutive good intervals seen; period is locked
module delay_pulse_monitor
   import delay_mon_pkg::*;
#(
   parameter int N        = 10000,
   parameter int CBITS    = 14,
   parameter int TOL      = 2,
   parameter int GOOD_REQ = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pulse_in,
   output logic                 locked,
   output logic                 early_err,
   output logic                 late_err,
   output logic [CBITS-1:0]     last_interval,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   // Wide enough to hold 0..GOOD_REQ.
   localparam int GW = (GOOD_REQ < 1) ? 1 : $clog2(GOOD_REQ + 1);
   localparam logic [GW-1:0] GOOD_REQ_V = GW'(GOOD_REQ);

   mon_state_t state_q, state_d;

   logic [GW-1:0]        good_cnt_q, good_cnt_d;
   logic [GW-1:0]        good_cnt_inc;
   logic [CBITS-1:0]     last_interval_q, last_interval_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 locked_q, locked_d;
   logic                 early_err_q, early_err_d;
   logic                 late_err_q, late_err_d;

   logic                 early_ev;
   logic                 late_ev;

   logic [CBITS-1:0]     cnt;
   logic                 ctr_early;
   logic                 ctr_good;
   logic                 ctr_timeout;
   logic                 ctr_clear;
   logic                 ctr_hold;

   // A pulse always starts a new interval; a timeout restarts the count for HUNT.
   assign ctr_hold  = (state_q == HUNT);
   assign ctr_clear = pulse_in || ctr_timeout;

   delay_interval_ctr #(
      .N     (N),
      .CBITS (CBITS),
      .TOL   (TOL)
   ) u_ctr (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (ctr_clear),
      .hold_i    (ctr_hold),
      .cnt_o     (cnt),
      .early_o   (ctr_early),
      .good_o    (ctr_good),
      .timeout_o (ctr_timeout)
   );

   assign good_cnt_inc = (good_cnt_q == GOOD_REQ_V) ? good_cnt_q : good_cnt_q + 1'b1;

   // Next-state, interval capture and error event decode.
   always_comb begin
      state_d         = state_q;
      good_cnt_d      = good_cnt_q;
      last_interval_d = last_interval_q;
      early_ev        = 1'b0;
      late_ev         = 1'b0;

      unique case (state_q)
         HUNT: begin
            if (pulse_in) begin
               state_d    = TRACK;
               good_cnt_d = '0;
            end
         end
         TRACK, LOCKED: begin
            if (pulse_in) begin
               if (ctr_good) begin
                  last_interval_d = cnt + 1'b1;
                  good_cnt_d      = good_cnt_inc;
                  if (good_cnt_inc >= GOOD_REQ_V) begin
                     state_d = LOCKED;
                  end
               end else if (ctr_early) begin
                  // The early pulse becomes the new reference point.
                  early_ev   = 1'b1;
                  good_cnt_d = '0;
                  state_d    = TRACK;
               end
            end else if (ctr_timeout) begin
               late_ev    = 1'b1;
               good_cnt_d = '0;
               state_d    = HUNT;
            end
         end
         default: begin
            state_d    = HUNT;
            good_cnt_d = '0;
         end
      endcase
   end

   // Error counter, lock indication and error flags.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (early_ev || late_ev) begin
         err_cnt_d = err_sat_inc(err_cnt_q);
      end

      locked_d = (state_d == LOCKED);

`ifdef DELAY_MON_STICKY_EN
      early_err_d = early_err_q || early_ev;
      late_err_d  = late_err_q || late_ev;
`else
      early_err_d = early_ev;
      late_err_d  = late_ev;
`endif
   end

   // State and output registers; reset overrides any pulse or timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= HUNT;
         good_cnt_q      <= '0;
         last_interval_q <= '0;
         err_cnt_q       <= '0;
         locked_q        <= 1'b0;
         early_err_q     <= 1'b0;
         late_err_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         good_cnt_q      <= good_cnt_d;
         last_interval_q <= last_interval_d;
         err_cnt_q       <= err_cnt_d;
         locked_q        <= locked_d;
         early_err_q     <= early_err_d;
         late_err_q      <= late_err_d;
      end
   end

   assign locked        = locked_q;
   assign early_err     = early_err_q;
   assign late_err      = late_err_q;
   assign last_interval = last_interval_q;
   assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_delay_pulse_monitor.sv
// Directed bench for delay_pulse_monitor with N=8, TOL=1, GOOD_REQ=2
// (nominal interval 9, accepted 8..10). Honours DELAY_MON_STICKY_EN.
module tb_delay_pulse_monitor;

   localparam int N        = 8;
   localparam int CBITS    = 5;
   localparam int TOL      = 1;
   localparam int GOOD_REQ = 2;

`ifdef DELAY_MON_STICKY_EN
   localparam bit STICKY = 1'b1;
`else
   localparam bit STICKY = 1'b0;
`endif

   logic             clk;
   logic             rst;
   logic             pulse_in;
   logic             locked;
   logic             early_err;
   logic             late_err;
   logic [CBITS-1:0] last_interval;
   logic [7:0]       err_cnt;

   int total;
   int bad;
   bit seen_early;
   bit seen_late;

   delay_pulse_monitor #(
      .N        (N),
      .CBITS    (CBITS),
      .TOL      (TOL),
      .GOOD_REQ (GOOD_REQ)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pulse_in      (pulse_in),
      .locked        (locked),
      .early_err     (early_err),
      .late_err      (late_err),
      .last_interval (last_interval),
      .err_cnt       (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Apply pulse_in for one clock edge, then settle just after the edge.
   task automatic step(input logic p);
      pulse_in = p;
      @(posedge clk);
      #1;
   endtask

   // Next pulse closes an interval of k cycles.
   task automatic send(input int k);
      repeat (k - 1) step(1'b0);
      step(1'b1);
   endtask

   function automatic logic [31:0] exp_early(input bit now);
      return {31'd0, now | (STICKY & seen_early)};
   endfunction

   function automatic logic [31:0] exp_late(input bit now);
      return {31'd0, now | (STICKY & seen_late)};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0);
      step(1'b0);
      rst = 1'b0;
      seen_early = 1'b0;
      seen_late  = 1'b0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      seen_early = 1'b0;
      seen_late  = 1'b0;
      rst        = 1'b1;
      pulse_in   = 1'b0;

      // Reset state
      do_reset();
      chk("rst_locked", locked, 0);
      chk("rst_early", early_err, 0);
      chk("rst_late", late_err, 0);
      chk("rst_last", last_interval, 0);
      chk("rst_errcnt", err_cnt, 0);

      // Nominal period: lock on the 3rd pulse, 20 pulses in total
      step(1'b1);
      chk("p1_locked", locked, 0);
      send(9);
      chk("p2_locked", locked, 0);
      chk("p2_last", last_interval, 9);
      send(9);
      chk("p3_locked", locked, 1);
      chk("p3_last", last_interval, 9);
      for (int i = 4; i <= 20; i++) begin
         send(9);
         chk("nom_locked", locked, 1);
         chk("nom_early", early_err, 0);
         chk("nom_late", late_err, 0);
      end
      chk("nom_last", last_interval, 9);
      chk("nom_errcnt", err_cnt, 0);

      // Edge intervals while locked; 10 hits cnt==N+TOL and is still good
      send(8);
      chk("i8_last", last_interval, 8);
      chk("i8_locked", locked, 1);
      send(10);
      chk("i10_last", last_interval, 10);
      chk("i10_locked", locked, 1);
      chk("i10_late", late_err, 0);
      chk("i10_errcnt", err_cnt, 0);
      step(1'b0);
      chk("i10_late_after", late_err, 0);

      // Early pulse after 6 cycles drops lock; re-lock after 2 good intervals
      send(6);
      seen_early = 1'b1;
      chk("early_flag", early_err, 1);
      chk("early_errcnt", err_cnt, 1);
      chk("early_locked", locked, 0);
      chk("early_last", last_interval, 10);
      send(9);
      chk("early_flag_next", early_err, exp_early(1'b0));
      chk("relock1_locked", locked, 0);
      send(9);
      chk("relock2_locked", locked, 1);
      chk("relock_early", early_err, exp_early(1'b0));

      // Pulses stop: late after cnt reaches 9
      repeat (9) step(1'b0);
      chk("late_pre", late_err, 0);
      chk("late_pre_locked", locked, 1);
      step(1'b0);
      seen_late = 1'b1;
      chk("late_flag", late_err, 1);
      chk("late_early", early_err, exp_early(1'b0));
      chk("late_locked", locked, 0);
      chk("late_errcnt", err_cnt, 2);
      repeat (15) step(1'b0);
      chk("late_flag_after", late_err, exp_late(1'b0));
      chk("hunt_errcnt", err_cnt, 2);
      step(1'b1);
      chk("hunt_exit_locked", locked, 0);
      chk("hunt_exit_errcnt", err_cnt, 2);
      send(9);
      chk("hunt_relock1", locked, 0);
      send(9);
      chk("hunt_relock2", locked, 1);

      // Reset mid-interval while locked, with a pulse present: reset wins
      repeat (4) step(1'b0);
      rst = 1'b1;
      step(1'b1);
      rst = 1'b0;
      seen_early = 1'b0;
      seen_late  = 1'b0;
      chk("mrst_locked", locked, 0);
      chk("mrst_early", early_err, 0);
      chk("mrst_late", late_err, 0);
      chk("mrst_last", last_interval, 0);
      chk("mrst_errcnt", err_cnt, 0);
      step(1'b1);
      chk("mrst_track_early", early_err, 0);
      chk("mrst_track_errcnt", err_cnt, 0);
      send(9);
      chk("mrst_p2_locked", locked, 0);
      chk("mrst_p2_last", last_interval, 9);
      send(9);
      chk("mrst_p3_locked", locked, 1);

      // Held-high pulse_in: every cycle is an early event; counter saturates
      do_reset();
      step(1'b1);
      chk("hold_first_errcnt", err_cnt, 0);
      repeat (254) step(1'b1);
      seen_early = 1'b1;
      chk("hold_254", err_cnt, 254);
      chk("hold_early", early_err, 1);
      step(1'b1);
      chk("hold_255", err_cnt, 255);
      repeat (45) step(1'b1);
      chk("hold_300", err_cnt, 255);
      chk("hold_locked", locked, 0);
      step(1'b0);
      chk("hold_release_early", early_err, exp_early(1'b0));
      chk("hold_release_errcnt", err_cnt, 255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
